mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the core's instruction-fetch port and data port.
// - Sits between mips_core and the unified memory.
// - Arbitrates per access with data priority and a fetch-starvation guard.
// - Sequences issue, wait and return through a small FSM with one outstanding access.
// - The core stalls on its own ports until each ports' rvalid.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_prio_sel.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Data-priority winner select with a fetch-starvation counter that forces
// one fetch win after STARVE_MAX consecutive losses.
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic issue,
  output src_t win_src,
  output logic win_valid
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          if_starved;

  assign if_starved = if_req && (starve_cnt == STARVE_TOP);

  always_comb begin
    win_valid = if_req || d_req;
    win_src   = (d_req && !if_starved) ? SRC_D : SRC_IF;
  end

  // Any idle cycle of the fetch port forgives its past losses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (issue) begin
      if (win_src == SRC_D) begin
        if (starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports, one
// outstanding access at a time, with data priority and a starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_TOP = LW'(MEM_LAT);

  arb_state_t    state;
  logic [LW-1:0] lat_cnt;
  logic          pend_we;
  src_t          win_src;
  logic          win_valid;
  logic          issue;
  logic          ret_now;

  assign issue   = reset && (state == IDLE) && win_valid;
  assign ret_now = reset && (state != IDLE) && (lat_cnt == LAT_TOP);

  arb_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .d_req    (d_req),
    .issue    (issue),
    .win_src  (win_src),
    .win_valid(win_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= (win_src == SRC_D) ? WAIT_D : WAIT_IF;
            lat_cnt <= LW'(1);
            pend_we <= (win_src == SRC_D) && d_we;
          end
        end
        WAIT_IF, WAIT_D: begin
          if (lat_cnt == LAT_TOP) begin
            state   <= IDLE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          lat_cnt <= '0;
        end
      endcase
    end
  end

  // Issue side is combinational so a request is granted in the cycle it is seen.
  always_comb begin
    if_gnt    = issue && (win_src == SRC_IF);
    d_gnt     = issue && (win_src == SRC_D);
    mem_en    = issue;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) mem_addr = d_addr;
    else if (if_gnt) mem_addr = if_addr;
    if (d_gnt && d_we) mem_wdata = d_wdata;
  end

  always_comb begin
    if_rvalid = ret_now && (state == WAIT_IF);
    d_rvalid  = ret_now && (state == WAIT_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !pend_we) ? mem_rdata : '0;
    busy      = reset && (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-count
// reference model of the arbitration and latency rules.
module tb_mem_port_arbiter;

  localparam int LAT = 1;
  localparam int SM  = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clock, reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_q;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SM)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (mem_en) mem_q <= mem_addr;
  assign mem_rdata = mem_q ^ K;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state: cycle numbers of the next free slot and pending return.
  int          cyc = 0;
  int          free_at = 0;
  int          ret_at = -1;
  bit          ret_d, ret_we;
  logic [31:0] ret_addr;
  int          starve = 0;
  bit          grant_log[$];

  logic        o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_mem_en, o_mem_we, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_wdata;

  task automatic model_and_check();
    logic e_ifg, e_dg, e_en, e_we, e_ifv, e_dv, e_busy;
    logic [31:0] e_addr, e_wd, e_ifd, e_dd;
    bit idle, dwin, ifwin;
    {e_ifg, e_dg, e_en, e_we, e_ifv, e_dv, e_busy} = '0;
    {e_addr, e_wd, e_ifd, e_dd} = '0;
    dwin = 0; ifwin = 0;
    if (!reset) begin
      free_at = cyc + 1;
      ret_at  = -1;
      starve  = 0;
    end else begin
      if (ret_at == cyc) begin
        if (ret_d) begin
          e_dv = 1;
          e_dd = ret_we ? 32'h0 : (ret_addr ^ K);
        end else begin
          e_ifv = 1;
          e_ifd = ret_addr ^ K;
        end
      end
      idle   = (cyc >= free_at);
      e_busy = !idle;
      if (idle) begin
        dwin  = d_req && !(if_req && starve == SM);
        ifwin = !dwin && if_req;
        if (dwin) begin
          e_dg = 1; e_en = 1; e_we = d_we; e_addr = d_addr;
          e_wd = d_we ? d_wdata : 32'h0;
          ret_d = 1; ret_we = d_we; ret_addr = d_addr;
        end else if (ifwin) begin
          e_ifg = 1; e_en = 1; e_addr = if_addr;
          ret_d = 0; ret_we = 0; ret_addr = if_addr;
        end
        if (dwin || ifwin) begin
          ret_at  = cyc + LAT;
          free_at = cyc + LAT + 1;
          grant_log.push_back(dwin);
        end
      end
      if (!if_req) starve = 0;
      else if (dwin) starve = (starve < SM) ? starve + 1 : SM;
      else if (ifwin) starve = 0;
    end
    chk("if_gnt", if_gnt, e_ifg);
    chk("d_gnt", d_gnt, e_dg);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_rvalid", if_rvalid, e_ifv);
    chk("if_rdata", if_rdata, e_ifd);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("d_rdata", d_rdata, e_dd);
    chk("busy", busy, e_busy);
    o_if_gnt = if_gnt; o_d_gnt = d_gnt; o_if_rvalid = if_rvalid; o_d_rvalid = d_rvalid;
    o_mem_en = mem_en; o_mem_we = mem_we; o_busy = busy;
    o_if_rdata = if_rdata; o_d_rdata = d_rdata; o_mem_wdata = mem_wdata;
    cyc++;
  endtask

  task automatic step();
    @(negedge clock);
    model_and_check();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit exp_order[6];
    exp_order = '{1, 1, 1, 1, 0, 1};
    reset = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) step();
    reset = 1;
    step();

    // Single fetch
    if_req = 1; if_addr = 32'h10;
    step(); chk("sf_gnt", o_if_gnt, 1);
    if_req = 0;
    step(); chk("sf_rvalid", o_if_rvalid, 1); chk("sf_rdata", o_if_rdata, 32'hA5A5_0010);
    step(); chk("sf_busy", o_busy, 0);

    // Simultaneous fetch and load
    if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h40;
    step(); chk("sim_dgnt", o_d_gnt, 1); chk("sim_ifgnt0", o_if_gnt, 0);
    d_req = 0;
    step(); chk("sim_drdata", o_d_rdata, 32'hA5A5_0040);
    step(); chk("sim_ifgnt", o_if_gnt, 1);
    if_req = 0;
    step();

    // Store
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
    step(); chk("st_we", o_mem_we, 1); chk("st_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    d_req = 0; d_we = 0;
    step(); chk("st_rvalid", o_d_rvalid, 1); chk("st_rdata", o_d_rdata, 0);

    // Starvation guard
    grant_log.delete();
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 6) chk("starve_full", dut.u_sel.starve_cnt, SM);
      if (i == 8) chk("starve_clr", dut.u_sel.starve_cnt, 0);
    end
    chk("starve_ngnt", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("starve_order%0d", i), grant_log[i], exp_order[i]);
    if_req = 0; d_req = 0;
    step();

    // Reset during WAIT_D
    d_req = 1; d_addr = 32'h44;
    step(); chk("rst_gnt", o_d_gnt, 1);
    d_req = 0; reset = 0;
    step(); chk("rst_norv", o_d_rvalid, 0); chk("rst_busy", o_busy, 0);
    reset = 1; d_req = 1; d_addr = 32'h48;
    step(); chk("rst_regnt", o_d_gnt, 1);
    d_req = 0;
    step();

    // Fetch request dropped while data access in flight
    d_req = 1; d_addr = 32'h50;
    step();
    d_req = 0; if_req = 1; if_addr = 32'h60;
    step(); chk("drop_gnt", o_if_gnt, 0);
    if_req = 0;
    step(); chk("drop_en", o_mem_en, 0);

    // Randomized traffic with occasional drops and resets
    for (int i = 0; i < 3000; i++) begin
      step();
      if (if_req && o_if_gnt) if_req = 0;
      if (d_req && o_d_gnt) d_req = 0;
      if (!if_req && ($urandom % 3 == 0)) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (if_req && ($urandom % 32 == 0)) if_req = 0;
      if (!d_req && ($urandom % 2 == 0)) begin
        d_req = 1; d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end else if (d_req && ($urandom % 32 == 0)) d_req = 0;
      reset = ($urandom % 150 != 0);
    end
    reset = 1; if_req = 0; d_req = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
